// File: rtl/vga_pkg.sv
// Shared VGA stream types and screen encodings for the display pipeline.
package vga_pkg;

  localparam int unsigned VGA_CNT_W = 11;
  localparam int unsigned VGA_RGB_W = 12;

  localparam int unsigned FINISH_HOLD_FRAMES = 120;

  typedef enum logic [1:0] {
    SCR_START  = 2'd0,
    SCR_PLAY   = 2'd1,
    SCR_FINISH = 2'd2
  } screen_t;

  typedef struct packed {
    logic [VGA_CNT_W-1:0] vcount;
    logic [VGA_CNT_W-1:0] hcount;
    logic                 vsync;
    logic                 hsync;
    logic                 vblnk;
    logic                 hblnk;
    logic [VGA_RGB_W-1:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/vga_if.sv
// One registered VGA stream: timing counters, sync/blank flags and pixel colour.
interface vga_if;
  import vga_pkg::*;

  logic [VGA_CNT_W-1:0] vcount;
  logic [VGA_CNT_W-1:0] hcount;
  logic                 vsync;
  logic                 hsync;
  logic                 vblnk;
  logic                 hblnk;
  logic [VGA_RGB_W-1:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a raw button followed by a registered rising-edge pulse.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_press <= r_sync & ~r_prev;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/screen_select.sv
// Game-flow FSM plus frame-aligned multiplexer choosing which renderer stream
// reaches the output stage.
module screen_select
  import vga_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = FINISH_HOLD_FRAMES,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       restart_btn,
  input  logic       game_over,
  vga_if.in          start_in,
  vga_if.in          game_in,
  vga_if.in          finish_in,
  vga_if.out         vga_out,
  output logic [1:0] state_o,
  output logic       frame_tick
);

  screen_t          r_state;
  screen_t          w_next;
  screen_t          r_sel;
  screen_t          w_sel;
  logic [CNT_W-1:0] r_hold;
  logic             w_hold_done;
  logic             w_start_press;
  logic             w_restart_press;
  logic             w_boundary;
  logic             r_tick;
  vga_bus_t         w_start;
  vga_bus_t         w_game;
  vga_bus_t         w_finish;
  vga_bus_t         w_mux;
  vga_bus_t         r_out;

  btn_sync u_start_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (start_btn),
    .o_press (w_start_press)
  );

  btn_sync u_restart_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (restart_btn),
    .o_press (w_restart_press)
  );

  // start_in is the timing reference; all renderer streams are aligned to it.
  assign w_boundary  = (start_in.vcount == '0) && (start_in.hcount == '0);
  assign w_hold_done = (r_hold == CNT_W'(HOLD_FRAMES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SCR_START;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SCR_START:  if (w_start_press)                  w_next = SCR_PLAY;
      SCR_PLAY:   if (game_over)                      w_next = SCR_FINISH;
      SCR_FINISH: if (w_restart_press && w_hold_done) w_next = SCR_START;
      default:                                        w_next = SCR_START;
    endcase
  end

  // Held at zero outside FINISH, which gives the clear-on-entry behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (r_state != SCR_FINISH) begin
      r_hold <= '0;
    end else if (r_tick && !w_hold_done) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // The boundary pixel itself must already use the newly loaded select.
  assign w_sel = w_boundary ? r_state : r_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= SCR_START;
      r_tick <= 1'b0;
    end else begin
      r_sel  <= w_sel;
      r_tick <= w_boundary;
    end
  end

  assign w_start  = {start_in.vcount, start_in.hcount, start_in.vsync, start_in.hsync,
                     start_in.vblnk, start_in.hblnk, start_in.rgb};
  assign w_game   = {game_in.vcount, game_in.hcount, game_in.vsync, game_in.hsync,
                     game_in.vblnk, game_in.hblnk, game_in.rgb};
  assign w_finish = {finish_in.vcount, finish_in.hcount, finish_in.vsync, finish_in.hsync,
                     finish_in.vblnk, finish_in.hblnk, finish_in.rgb};

  always_comb begin
    w_mux = w_start;
    case (w_sel)
      SCR_PLAY:   w_mux = w_game;
      SCR_FINISH: w_mux = w_finish;
      default:    w_mux = w_start;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= '0;
    else        r_out <= w_mux;
  end

  assign vga_out.vcount = r_out.vcount;
  assign vga_out.hcount = r_out.hcount;
  assign vga_out.vsync  = r_out.vsync;
  assign vga_out.hsync  = r_out.hsync;
  assign vga_out.vblnk  = r_out.vblnk;
  assign vga_out.hblnk  = r_out.hblnk;
  assign vga_out.rgb    = r_out.rgb;

  assign state_o    = r_state;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_screen_select.sv
// Bench for screen_select: small 16x8 frames, per-cycle scoreboard of the muxed
// stream, a table of game-flow events and directed multi-cycle corner cases.
module tb_screen_select;
  import vga_pkg::*;

  localparam int unsigned H_TOT = 16;
  localparam int unsigned V_TOT = 8;
  localparam int unsigned HOLD  = FINISH_HOLD_FRAMES;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       restart_btn = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] state_o;
  logic       frame_tick;

  vga_if start_if ();
  vga_if game_if ();
  vga_if finish_if ();
  vga_if out_if ();

  screen_select #(.HOLD_FRAMES(FINISH_HOLD_FRAMES), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_btn   (start_btn),
    .restart_btn (restart_btn),
    .game_over   (game_over),
    .start_in    (start_if),
    .game_in     (game_if),
    .finish_in   (finish_if),
    .vga_out     (out_if),
    .state_o     (state_o),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
  } pix_t;

  typedef enum int unsigned {EV_NONE, EV_START, EV_RESTART, EV_GO} ev_t;

  typedef struct {
    string       name;
    int unsigned wait_f;
    int unsigned at_v;
    int unsigned at_h;
    ev_t         ev;
    screen_t     exp_state;
    screen_t     exp_now;
    screen_t     exp_next;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned h = 3;
  int unsigned v = 5;
  pix_t        sbq[$];

  screen_t     m_state;
  screen_t     m_disp;
  logic        m_tick;
  int unsigned m_hold;
  logic [2:0]  s_pipe;
  logic [2:0]  r_pipe;
  logic        s_prev;
  logic        r_prev;

  function automatic pix_t gen(int unsigned sid, int unsigned hh, int unsigned vv);
    pix_t p;
    p.vcount = 11'(vv);
    p.hcount = 11'(hh);
    p.hblnk  = (hh >= 12);
    p.hsync  = (hh >= 12 + sid) && (hh < 14 + sid);
    p.vblnk  = (vv >= 6);
    p.vsync  = (vv == 7);
    p.rgb    = {2'(sid + 1), 10'((vv * H_TOT + hh) ^ (sid * 341))};
    return p;
  endfunction

  function automatic vec_t mk(string n, int unsigned w, int unsigned av, int unsigned ah,
                              ev_t e, screen_t es, screen_t en, screen_t ex);
    vec_t r;
    r.name = n; r.wait_f = w; r.at_v = av; r.at_h = ah; r.ev = e;
    r.exp_state = es; r.exp_now = en; r.exp_next = ex;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = SCR_START;
    m_disp  = SCR_START;
    m_tick  = 1'b0;
    m_hold  = 0;
    s_pipe  = '0;
    r_pipe  = '0;
    s_prev  = 1'b0;
    r_prev  = 1'b0;
  endtask

  function automatic pix_t out_pix();
    return {out_if.vcount, out_if.hcount, out_if.vsync, out_if.hsync,
            out_if.vblnk, out_if.hblnk, out_if.rgb};
  endfunction

  task automatic drive(input pix_t ps, input pix_t pg, input pix_t pf);
    start_if.vcount = ps.vcount;  start_if.hcount = ps.hcount;
    start_if.vsync  = ps.vsync;   start_if.hsync  = ps.hsync;
    start_if.vblnk  = ps.vblnk;   start_if.hblnk  = ps.hblnk;  start_if.rgb = ps.rgb;
    game_if.vcount  = pg.vcount;  game_if.hcount  = pg.hcount;
    game_if.vsync   = pg.vsync;   game_if.hsync   = pg.hsync;
    game_if.vblnk   = pg.vblnk;   game_if.hblnk   = pg.hblnk;  game_if.rgb = pg.rgb;
    finish_if.vcount = pf.vcount; finish_if.hcount = pf.hcount;
    finish_if.vsync  = pf.vsync;  finish_if.hsync  = pf.hsync;
    finish_if.vblnk  = pf.vblnk;  finish_if.hblnk  = pf.hblnk; finish_if.rgb = pf.rgb;
  endtask

  // One pixel: drive inputs, queue the expected output, clock, compare.
  task automatic step();
    pix_t    ps, pg, pf, exp, got;
    logic    b;
    screen_t sel, nxt;
    ps = gen(0, h, v);
    pg = gen(1, h, v);
    pf = gen(2, h, v);
    drive(ps, pg, pf);
    b   = (h == 0) && (v == 0);
    sel = b ? m_state : m_disp;
    if (!rst_n)                 exp = '0;
    else if (sel == SCR_PLAY)   exp = pg;
    else if (sel == SCR_FINISH) exp = pf;
    else                        exp = ps;
    sbq.push_back(exp);
    nxt = m_state;
    case (m_state)
      SCR_START:  if (s_pipe[2]) nxt = SCR_PLAY;
      SCR_PLAY:   if (game_over) nxt = SCR_FINISH;
      SCR_FINISH: if (r_pipe[2] && m_hold == HOLD) nxt = SCR_START;
      default:    nxt = SCR_START;
    endcase
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_state != SCR_FINISH)               m_hold = 0;
      else if (m_tick && m_hold < HOLD)        m_hold++;
      m_state = nxt;
      if (b) m_disp = sel;
      m_tick = b;
      s_pipe = {s_pipe[1:0], start_btn & ~s_prev};
      r_pipe = {r_pipe[1:0], restart_btn & ~r_prev};
      s_prev = start_btn;
      r_prev = restart_btn;
    end
    if (h == H_TOT - 1) begin
      h = 0;
      v = (v == V_TOT - 1) ? 0 : v + 1;
    end else begin
      h++;
    end
    #1;
    exp = sbq.pop_front();
    got = out_pix();
    check("vga_out", 64'(got), 64'(exp));
    check("state_o", 64'(state_o), 64'(m_state));
    check("frame_tick", 64'(frame_tick), 64'(m_tick));
  endtask

  task automatic run_to(input int unsigned tv, input int unsigned th);
    int unsigned n;
    n = 0;
    while (!(h == th && v == tv) && n < 4 * H_TOT * V_TOT) begin
      step();
      n++;
    end
    if (!(h == th && v == tv)) begin
      total++;
      bad++;
      $display("FAIL run_to: position (%0d,%0d) not reached, at (%0d,%0d)", tv, th, v, h);
    end
  endtask

  task automatic check_tag(input string name, input screen_t s);
    logic [1:0] tag;
    tag = 2'(s) + 2'd1;
    check(name, 64'(out_if.rgb[11:10]), 64'(tag));
  endtask

  vec_t vecs[8];

  initial begin
    int unsigned ticks;
    vecs[0] = mk("idle",          1,  2, 3, EV_NONE,    SCR_START,  SCR_START,  SCR_START);
    vecs[1] = mk("start_mid",     1,  4, 8, EV_START,   SCR_PLAY,   SCR_START,  SCR_PLAY);
    vecs[2] = mk("start_in_play", 1,  1, 5, EV_START,   SCR_PLAY,   SCR_PLAY,   SCR_PLAY);
    vecs[3] = mk("go_play",       1,  2, 3, EV_GO,      SCR_FINISH, SCR_PLAY,   SCR_FINISH);
    vecs[4] = mk("go_finish",     1,  3, 0, EV_GO,      SCR_FINISH, SCR_FINISH, SCR_FINISH);
    vecs[5] = mk("restart_early", 50, 1, 1, EV_RESTART, SCR_FINISH, SCR_FINISH, SCR_FINISH);
    vecs[6] = mk("restart_ok",    75, 1, 1, EV_RESTART, SCR_START,  SCR_FINISH, SCR_START);
    vecs[7] = mk("go_start",      1,  2, 9, EV_GO,      SCR_START,  SCR_START,  SCR_START);

    model_reset();
    drive(gen(0, h, v), gen(1, h, v), gen(2, h, v));
    @(posedge clk);
    #1;
    check("rst_vga_out", 64'(out_pix()), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_tick", 64'(frame_tick), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;

    run_to(0, 0);
    ticks = 0;
    repeat (H_TOT * V_TOT) begin
      step();
      ticks += 32'(frame_tick);
    end
    check("ticks_per_frame", 64'(ticks), 64'd1);

    foreach (vecs[i]) begin
      repeat (vecs[i].wait_f) begin
        step();
        run_to(0, 0);
      end
      run_to(vecs[i].at_v, vecs[i].at_h);
      case (vecs[i].ev)
        EV_START:   begin start_btn = 1'b1;   repeat (6) step(); start_btn = 1'b0;   end
        EV_RESTART: begin restart_btn = 1'b1; repeat (6) step(); restart_btn = 1'b0; end
        EV_GO:      begin game_over = 1'b1;   step();            game_over = 1'b0;   end
        default:    step();
      endcase
      repeat (8) step();
      check({vecs[i].name, "_state"}, 64'(state_o), 64'(vecs[i].exp_state));
      check_tag({vecs[i].name, "_now"}, vecs[i].exp_now);
      run_to(0, 0);
      repeat (3) step();
      check_tag({vecs[i].name, "_next"}, vecs[i].exp_next);
    end

    // game_over on the boundary cycle: that frame still shows PLAY
    start_btn = 1'b1;
    repeat (6) step();
    start_btn = 1'b0;
    run_to(0, 0);
    step();
    run_to(0, 0);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    repeat (3) step();
    check("go_bnd_state", 64'(state_o), 64'(SCR_FINISH));
    check_tag("go_bnd_now", SCR_PLAY);
    run_to(0, 0);
    repeat (3) step();
    check_tag("go_bnd_next", SCR_FINISH);

    // asynchronous reset in the middle of line 2
    run_to(2, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vga_out", 64'(out_pix()), 64'd0);
    check("arst_state", 64'(state_o), 64'd0);
    check("arst_tick", 64'(frame_tick), 64'd0);
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("arst_rel_state", 64'(state_o), 64'(SCR_START));
    check_tag("arst_rel_now", SCR_START);
    repeat (10) step();

    // two transitions inside one frame: PLAY never reaches the display
    run_to(1, 0);
    start_btn = 1'b1;
    repeat (3) step();
    check("lat_before", 64'(state_o), 64'(SCR_START));
    step();
    check("lat_at4", 64'(state_o), 64'(SCR_PLAY));
    repeat (2) step();
    start_btn = 1'b0;
    repeat (8) step();
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    step();
    check("two_state", 64'(state_o), 64'(SCR_FINISH));
    check_tag("two_now", SCR_START);
    run_to(0, 0);
    repeat (3) step();
    check_tag("two_next", SCR_FINISH);
    run_to(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
